// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the pipeline control blocks.
// State encoding of the hazard FSM, the hard-wired zero register and default counter width.
// No logic; pure declarations plus one compare helper.
package mips_pipe_pkg;

    typedef enum logic {
        HZ_RUN  = 1'b0,
        HZ_LDBR = 1'b1
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         CNT_W    = 16;

    // A destination only creates a dependency if it is a real register ($0 is constant).
    function automatic logic regHit(input logic [4:0] dest, input logic [4:0] src);
        return (dest != REG_ZERO) && (dest == src);
    endfunction

endpackage

// File: rtl/hazard_detect_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
// Latency: count visible the cycle after inc; sticks at all-ones instead of wrapping.
// No backpressure; caller gates inc.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] MAX = {W{1'b1}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (inc && (q != MAX)) begin
            q <= q + ONE;
        end
    end

endmodule

// File: rtl/hazard_detect.sv
// ID-stage hazard unit: load-use / branch-operand stalls, taken-branch flush, memory freeze.
// Latency: all controls are combinational in the current cycle; only FSM and counters are registered.
// Backpressure: MemBusy freezes everything and overrides stall, which in turn overrides flush.
module hazard_detect
    import mips_pipe_pkg::*;
#(
    parameter int CNT_W = mips_pipe_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IfIdRs,
    input  logic [4:0]       IfIdRt,
    input  logic             IfIdUsesRt,
    input  logic             IdBranch,
    input  logic             BranchTaken,
    input  logic             IdExMemRead,
    input  logic             IdExRegWrite,
    input  logic [4:0]       IdExRt,
    input  logic [4:0]       IdExRd,
    input  logic             ExMemMemRead,
    input  logic [4:0]       ExMemRd,
    input  logic             MemBusy,
    output logic             PcWrite,
    output logic             IfIdWrite,
    output logic             IdExBubble,
    output logic             IfIdFlush,
    output logic             PipeFreeze,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    hz_state_e state, stateNxt;

    logic loadUse, brAlu, brLoad, brMem, anyHaz;
    logic freeze, stall, flush;

    always_comb begin
        loadUse = IdExMemRead &
                  (regHit(IdExRt, IfIdRs) | (IfIdUsesRt & regHit(IdExRt, IfIdRt)));
        brAlu   = IdBranch & IdExRegWrite & !IdExMemRead &
                  (regHit(IdExRd, IfIdRs) | regHit(IdExRd, IfIdRt));
        brLoad  = IdBranch & IdExMemRead &
                  (regHit(IdExRt, IfIdRs) | regHit(IdExRt, IfIdRt));
        brMem   = IdBranch & ExMemMemRead &
                  (regHit(ExMemRd, IfIdRs) | regHit(ExMemRd, IfIdRt));
        anyHaz  = loadUse | brAlu | brLoad | brMem;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HZ_RUN;
        end else begin
            state <= stateNxt;
        end
    end

    // LDBR exists only to guarantee the second bubble of a load feeding a branch.
    always_comb begin
        stateNxt = state;
        if (!MemBusy) begin
            case (state)
                HZ_RUN:  if (brLoad) stateNxt = HZ_LDBR;
                HZ_LDBR: stateNxt = HZ_RUN;
                default: stateNxt = HZ_RUN;
            endcase
        end
    end

    always_comb begin
        freeze = MemBusy;
        stall  = !freeze & ((state == HZ_LDBR) | ((state == HZ_RUN) & anyHaz));
        flush  = !freeze & !stall & IdBranch & BranchTaken;
    end

    // Reset forces a safe bubble-and-hold pattern regardless of the pipeline inputs.
    always_comb begin
        PcWrite    = !freeze & !stall;
        IfIdWrite  = !freeze & !stall;
        IdExBubble = stall;
        IfIdFlush  = flush;
        PipeFreeze = freeze;
        if (!rst_n) begin
            PcWrite    = 1'b0;
            IfIdWrite  = 1'b0;
            IdExBubble = 1'b1;
            IfIdFlush  = 1'b0;
            PipeFreeze = 1'b0;
        end
    end

    sat_counter #(.W(CNT_W)) uStallCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall),
        .q     (StallCnt)
    );

    sat_counter #(.W(CNT_W)) uFlushCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush),
        .q     (FlushCnt)
    );

endmodule
